// File: rtl/ft_recovery_ctrl_if.sv
// Recovery controller bus: per-core error/halt inputs and the
// reset/halt/replay/status outputs toward the cores and shadow register file.
interface ft_recovery_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CORES  = 2,
    parameter int CNT_WIDTH  = 8,
    parameter int SEL_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
    logic [NUM_CORES-1:0]  error_i;
    logic [NUM_CORES-1:0]  halted_i;
    logic [NUM_CORES-1:0]  reset_o;
    logic                  halt_o;
    logic                  resume_o;
    logic                  shift_o;
    logic                  we_spc_o;
    logic                  we_sgpr_o;
    logic [ADDR_WIDTH-1:0] replay_addr_o;
    logic [SEL_W-1:0]      core_sel_o;
    logic                  busy_o;
    logic                  fail_o;
    logic [CNT_WIDTH-1:0]  recover_cnt_o;

    // Controller side
    modport slave (
        input  error_i, halted_i,
        output reset_o, halt_o, resume_o, shift_o, we_spc_o, we_sgpr_o,
               replay_addr_o, core_sel_o, busy_o, fail_o, recover_cnt_o
    );

    // Core / detector side
    modport master (
        output error_i, halted_i,
        input  reset_o, halt_o, resume_o, shift_o, we_spc_o, we_sgpr_o,
               replay_addr_o, core_sel_o, busy_o, fail_o, recover_cnt_o
    );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Multi-core rollback recovery controller. Picks the lowest-indexed faulty
// core, resets and halts it (with timed-out retries), replays PC and register
// file from the shadow copy, then resumes it. Gives up into a sticky FAIL
// state once all halt attempts time out.
module ft_recovery_ctrl #(
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_CORES    = 2,
    parameter int SKIP_X0      = 1,
    parameter int HALT_TIMEOUT = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ft_recovery_ctrl_if.slave bus
);
    localparam int SEL_W = (NUM_CORES > 1)    ? $clog2(NUM_CORES)    : 1;
    localparam int TMR_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRIES > 1)  ? $clog2(MAX_RETRIES)  : 1;

    localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(HALT_TIMEOUT - 1);
    localparam logic [RTY_W-1:0]      RTY_LAST  = RTY_W'(MAX_RETRIES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(SKIP_X0);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_HALT, S_HALT_WAIT,
        S_WORK_SPC, S_WORK_SGPR, S_DONE, S_FAIL
    } state_e;

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      core_sel_q, core_sel_d;
    logic [RTY_W-1:0]      retry_q, retry_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [NUM_CORES-1:0]  reset_q, reset_d;
    logic                  halt_q, halt_d;
    logic                  resume_q, resume_d;
    logic                  shift_q, shift_d;
    logic                  we_spc_q, we_spc_d;
    logic                  we_sgpr_q, we_sgpr_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;

    logic [SEL_W-1:0]      first_err;

    // Lowest-indexed core reporting an error (scan down so low index wins)
    always_comb begin
        first_err = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bus.error_i[i]) first_err = SEL_W'(i);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        core_sel_d = core_sel_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.error_i) begin
                    core_sel_d = first_err;
                    retry_d    = '0;
                    state_d    = S_RESET;
                end
            end
            S_RESET: state_d = S_HALT;
            S_HALT: begin
                timer_d = '0;
                state_d = S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                // An acknowledge arriving on the last wait cycle still counts
                if (bus.halted_i[core_sel_q]) begin
                    state_d = S_WORK_SPC;
                end else if (timer_q == TMR_LAST && retry_q == RTY_LAST) begin
                    state_d = S_FAIL;
                end else if (timer_q == TMR_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_RESET;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WORK_SPC: begin
                addr_d  = ADDR_FIRST;
                state_d = S_WORK_SGPR;
            end
            S_WORK_SGPR: begin
                if (addr_q == ADDR_LAST) state_d = S_DONE;
                else                     addr_d  = addr_q + 1'b1;
            end
            S_DONE: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state, then registered
    always_comb begin
        reset_d   = '1;
        halt_d    = 1'b0;
        resume_d  = 1'b0;
        shift_d   = 1'b0;
        we_spc_d  = 1'b0;
        we_sgpr_d = 1'b0;
        fail_d    = 1'b0;
        busy_d    = (state_d != S_IDLE) && (state_d != S_FAIL);
        case (state_d)
            S_RESET:     reset_d[core_sel_d] = 1'b0;
            S_HALT: begin
                halt_d  = 1'b1;
                shift_d = 1'b1;
            end
            S_WORK_SPC:  we_spc_d  = 1'b1;
            S_WORK_SGPR: we_sgpr_d = 1'b1;
            S_DONE:      resume_d  = 1'b1;
            S_FAIL: begin
                reset_d[core_sel_d] = 1'b0;
                fail_d              = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            core_sel_q <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            reset_q    <= '1;
            halt_q     <= 1'b0;
            resume_q   <= 1'b0;
            shift_q    <= 1'b0;
            we_spc_q   <= 1'b0;
            we_sgpr_q  <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_sel_q <= core_sel_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            reset_q    <= reset_d;
            halt_q     <= halt_d;
            resume_q   <= resume_d;
            shift_q    <= shift_d;
            we_spc_q   <= we_spc_d;
            we_sgpr_q  <= we_sgpr_d;
            busy_q     <= busy_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.reset_o       = reset_q;
    assign bus.halt_o        = halt_q;
    assign bus.resume_o      = resume_q;
    assign bus.shift_o       = shift_q;
    assign bus.we_spc_o      = we_spc_q;
    assign bus.we_sgpr_o     = we_sgpr_q;
    assign bus.replay_addr_o = addr_q;
    assign bus.core_sel_o    = core_sel_q;
    assign bus.busy_o        = busy_q;
    assign bus.fail_o        = fail_q;
    assign bus.recover_cnt_o = cnt_q;
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl: a default-parameter instance and a
// small (ADDR_WIDTH=3, SKIP_X0=0) instance, sampled 1 time unit after each edge.
module tb_ft_recovery_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int   tests = 0;
    int   fails = 0;
    int   cnt_a, cnt_b, cnt_c, bad, exp_addr, resume_at, k;

    ft_recovery_ctrl_if #(.ADDR_WIDTH(5), .NUM_CORES(2), .CNT_WIDTH(8)) f0 ();
    ft_recovery_ctrl_if #(.ADDR_WIDTH(3), .NUM_CORES(2), .CNT_WIDTH(8)) f1 ();

    ft_recovery_ctrl #(
        .ADDR_WIDTH(5), .NUM_CORES(2), .SKIP_X0(1),
        .HALT_TIMEOUT(16), .MAX_RETRIES(3), .CNT_WIDTH(8)
    ) dut0 (.clk_i(clk), .rst_i(rst0), .bus(f0));

    ft_recovery_ctrl #(
        .ADDR_WIDTH(3), .NUM_CORES(2), .SKIP_X0(0),
        .HALT_TIMEOUT(16), .MAX_RETRIES(3), .CNT_WIDTH(8)
    ) dut1 (.clk_i(clk), .rst_i(rst1), .bus(f1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst0();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
    endtask

    task automatic wait_idle0(input string tag, input int budget);
        int n;
        n = 0;
        while (f0.busy_o === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(f0.busy_o), 0);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        f0.error_i = '0; f0.halted_i = '0;
        f1.error_i = '0; f1.halted_i = '0;
        tick(); tick();

        // Reset state
        check("rst_reset_o",  32'(f0.reset_o), 3);
        check("rst_halt",     32'(f0.halt_o), 0);
        check("rst_resume",   32'(f0.resume_o), 0);
        check("rst_shift",    32'(f0.shift_o), 0);
        check("rst_we_spc",   32'(f0.we_spc_o), 0);
        check("rst_we_sgpr",  32'(f0.we_sgpr_o), 0);
        check("rst_addr",     32'(f0.replay_addr_o), 0);
        check("rst_core_sel", 32'(f0.core_sel_o), 0);
        check("rst_busy",     32'(f0.busy_o), 0);
        check("rst_fail",     32'(f0.fail_o), 0);
        check("rst_cnt",      32'(f0.recover_cnt_o), 0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
        check("idle_busy", 32'(f0.busy_o), 0);

        // Single recovery of core 1
        f0.halted_i = 2'b10;
        f0.error_i  = 2'b10;
        tick();
        f0.error_i  = 2'b00;
        check("t1_core_sel", 32'(f0.core_sel_o), 1);
        check("t1_reset_o",  32'(f0.reset_o), 1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; bad = 0; resume_at = 0; exp_addr = 1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            if (f0.reset_o !== 2'b11) cnt_a++;
            if (f0.we_spc_o === 1'b1) cnt_b++;
            if (f0.we_sgpr_o === 1'b1) begin
                cnt_c++;
                if (f0.replay_addr_o !== 5'(exp_addr)) bad++;
                exp_addr++;
            end
            if (f0.resume_o === 1'b1 && resume_at == 0) resume_at = c;
            if (f0.busy_o === 1'b1 && f0.core_sel_o !== 1'b1) bad++;
        end
        check("t1_reset_cycles", 32'(cnt_a), 1);
        check("t1_spc_pulses",   32'(cnt_b), 1);
        check("t1_sgpr_cycles",  32'(cnt_c), 31);
        check("t1_addr_seq",     32'(bad), 0);
        check("t1_resume_cycle", 32'(resume_at), 36);
        check("t1_cnt",          32'(f0.recover_cnt_o), 1);
        check("t1_idle",         32'(f0.busy_o), 0);

        // Both cores faulty, held: core 0 is recovered, core 1 starves
        pulse_rst0();
        f0.halted_i = 2'b11;
        f0.error_i  = 2'b11;
        tick();
        check("t2_first_core0", 32'(f0.reset_o), 2);
        cnt_a = 0; bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            if (f0.busy_o === 1'b1 && f0.core_sel_o !== 1'b0) bad++;
            if (f0.reset_o === 2'b10) cnt_a++;
            if (f0.reset_o === 2'b01) bad++;
        end
        check("t2_no_core1",     32'(bad), 0);
        check("t2_core0_twice",  32'(cnt_a), 2);
        check("t2_cnt_held",     32'(f0.recover_cnt_o), 1);

        // Switch to core 1 right after the first DONE
        pulse_rst0();
        f0.error_i = 2'b11;
        tick();
        for (int c = 2; c <= 36; c++) tick();
        check("t2b_done_resume", 32'(f0.resume_o), 1);
        check("t2b_done_core0",  32'(f0.core_sel_o), 0);
        f0.error_i = 2'b10;
        tick();
        check("t2b_idle_gap", 32'(f0.busy_o), 0);
        check("t2b_cnt1",     32'(f0.recover_cnt_o), 1);
        tick();
        f0.error_i = 2'b00;
        check("t2b_core1_sel",   32'(f0.core_sel_o), 1);
        check("t2b_core1_reset", 32'(f0.reset_o), 1);
        wait_idle0("t2b_finish", 60);
        check("t2b_cnt2", 32'(f0.recover_cnt_o), 2);

        // One halt timeout, then acknowledge on the second attempt
        pulse_rst0();
        f0.halted_i = 2'b00;
        f0.error_i  = 2'b01;
        tick();
        f0.error_i  = 2'b00;
        check("t3_reset1", 32'(f0.reset_o), 2);
        tick();
        check("t3_halt1",  32'(f0.halt_o), 1);
        check("t3_shift1", 32'(f0.shift_o), 1);
        for (int c = 0; c < 16; c++) tick();
        check("t3_wait_end_rst", 32'(f0.reset_o), 3);
        check("t3_wait_busy",    32'(f0.busy_o), 1);
        tick();
        check("t3_reset2", 32'(f0.reset_o), 2);
        tick();
        check("t3_halt2", 32'(f0.halt_o), 1);
        f0.halted_i = 2'b01;
        tick();
        tick();
        check("t3_we_spc", 32'(f0.we_spc_o), 1);
        wait_idle0("t3_finish", 60);
        check("t3_cnt",  32'(f0.recover_cnt_o), 1);
        check("t3_fail", 32'(f0.fail_o), 0);

        // Retries exhausted: sticky FAIL
        pulse_rst0();
        f0.halted_i = 2'b00;
        f0.error_i  = 2'b10;
        tick();
        f0.error_i  = 2'b00;
        cnt_a = 0;
        for (int c = 1; c <= 54; c++) begin
            if (c > 1) tick();
            if (f0.halt_o === 1'b1) cnt_a++;
        end
        check("t4_pre_fail", 32'(f0.fail_o), 0);
        check("t4_pre_busy", 32'(f0.busy_o), 1);
        tick();
        check("t4_fail",     32'(f0.fail_o), 1);
        check("t4_reset_o",  32'(f0.reset_o), 1);
        check("t4_busy",     32'(f0.busy_o), 0);
        check("t4_core_sel", 32'(f0.core_sel_o), 1);
        check("t4_halts",    32'(cnt_a), 3);
        f0.error_i = 2'b11;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (f0.fail_o !== 1'b1 || f0.reset_o !== 2'b01 ||
                f0.busy_o !== 1'b0 || f0.halt_o !== 1'b0) bad++;
        end
        check("t4_sticky", 32'(bad), 0);
        rst0 = 1'b1;
        f0.error_i = 2'b00;
        tick();
        check("t4_rst_fail",  32'(f0.fail_o), 0);
        check("t4_rst_reset", 32'(f0.reset_o), 3);
        check("t4_rst_sel",   32'(f0.core_sel_o), 0);
        check("t4_rst_busy",  32'(f0.busy_o), 0);
        rst0 = 1'b0;

        // Small instance without x0 skipping: addresses 0..7
        f1.halted_i = 2'b01;
        f1.error_i  = 2'b01;
        tick();
        f1.error_i  = 2'b00;
        cnt_c = 0; bad = 0; resume_at = 0; exp_addr = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) tick();
            if (f1.we_sgpr_o === 1'b1) begin
                cnt_c++;
                if (f1.replay_addr_o !== 3'(exp_addr)) bad++;
                exp_addr++;
            end
            if (f1.resume_o === 1'b1 && resume_at == 0) resume_at = c;
        end
        check("t5_sgpr_cycles", 32'(cnt_c), 8);
        check("t5_addr_seq",    32'(bad), 0);
        check("t5_resume",      32'(resume_at), 13);
        check("t5_cnt",         32'(f1.recover_cnt_o), 1);

        // Reset in the middle of the register replay
        f1.error_i = 2'b01;
        tick();
        f1.error_i = 2'b00;
        k = 0;
        while (!(f1.we_sgpr_o === 1'b1 && f1.replay_addr_o === 3'd4) && k < 30) begin
            tick();
            k++;
        end
        check("t5_at_addr4", 32'(f1.replay_addr_o), 4);
        rst1 = 1'b1;
        tick();
        check("t5_rst_sgpr", 32'(f1.we_sgpr_o), 0);
        check("t5_rst_busy", 32'(f1.busy_o), 0);
        check("t5_rst_addr", 32'(f1.replay_addr_o), 0);
        check("t5_rst_cnt",  32'(f1.recover_cnt_o), 0);
        rst1 = 1'b0;
        tick();
        check("t5_stay_idle", 32'(f1.busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ft_recovery_ctrl.md
# ft_recovery_ctrl

Parametrised recovery controller for the fault-tolerant multi-core system. It generalises single-core rollback to `NUM_CORES` monitored cores and selects the lowest-indexed faulty core. For that core it sequences reset, halt, PC and register-file replay from the shadow copy, then resume. Compared with the single-core controller, it adds a halt-acknowledge timeout with bounded retries, a sticky failure state, optional skipping of `x0`, and a saturating recovery counter. It sits between the per-core error detectors and the cores' debug/halt interface and shadow register file.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register-file address width; `NUM_REG = 2**ADDR_WIDTH`.
- `NUM_CORES`, 2: number of monitored cores; must be at least 1.
- `SKIP_X0`, 1: when 1, replay starts at address 1 (`x0` is hardwired); when 0, replay starts at address 0.
- `HALT_TIMEOUT`, 16: number of cycles to wait for halt acknowledge; must be at least 1.
- `MAX_RETRIES`, 3: number of reset/halt attempts before giving up; must be at least 1.
- `CNT_WIDTH`, 8: width of the recovery counter.

Ports:
- `clk_i`, in, 1: clock; all logic is on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `error_i`, in, `NUM_CORES`: per-core error flag, level-sensitive.
- `halted_i`, in, `NUM_CORES`: per-core halted acknowledge.
- `reset_o`, out, `NUM_CORES`: per-core reset, active-low.
- `halt_o`, out, 1: halt request to the selected core.
- `resume_o`, out, 1: resume request to the selected core.
- `shift_o`, out, 1: shadow-copy shift strobe.
- `we_spc_o`, out, 1: PC restore write enable.
- `we_sgpr_o`, out, 1: register restore write enable.
- `replay_addr_o`, out, `ADDR_WIDTH`: register address being restored.
- `core_sel_o`, out, `$clog2(NUM_CORES)` (minimum 1): index of the core under recovery.
- `busy_o`, out, 1: high in every state except IDLE and FAIL.
- `fail_o`, out, 1: sticky unrecoverable-fault flag.
- `recover_cnt_o`, out, `CNT_WIDTH`: count of completed recoveries, saturating.

## Operation
- FSM states: IDLE, RESET, HALT, HALT_WAIT, WORK_SPC, WORK_SGPR, DONE, FAIL.
- All outputs are registered and are pure functions of the current state and datapath registers (Moore).
- Reset (`rst_i`=1) values:
  - state IDLE;
  - `reset_o` all ones;
  - `halt_o`, `resume_o`, `shift_o`, `we_spc_o`, `we_sgpr_o` = 0;
  - `replay_addr_o`, `core_sel_o`, `recover_cnt_o`, retry counter, timer = 0;
  - `busy_o` and `fail_o` = 0.
- Reset mid-operation aborts immediately to these values, including clearing FAIL.
- IDLE transitions:
  - if any `error_i` bit is set, latch the lowest set index into `core_sel_o`, clear the retry counter, and go to RESET;
  - otherwise stay in IDLE.
- RESET (1 cycle): `reset_o[core_sel]`=0; all other bits stay 1. Next state is HALT.
- HALT (1 cycle): `halt_o`=1 and `shift_o`=1. Next state is HALT_WAIT; the timer is cleared on entry.
- HALT_WAIT:
  - if `halted_i[core_sel]`=1, go to WORK_SPC; halted takes priority over timeout in the same cycle;
  - else if timer = `HALT_TIMEOUT`-1 and retry counter = `MAX_RETRIES`-1, go to FAIL;
  - else if timer = `HALT_TIMEOUT`-1, increment the retry counter and go back to RESET;
  - otherwise increment the timer.
- WORK_SPC (1 cycle): `we_spc_o`=1. Next state is WORK_SGPR; `replay_addr_o` is set to `SKIP_X0`.
- WORK_SGPR:
  - `we_sgpr_o`=1 every cycle;
  - `replay_addr_o` increments by 1 per cycle;
  - when `replay_addr_o` = `NUM_REG`-1, go to DONE; there is no wrap-around.
- DONE (1 cycle): `resume_o`=1. Increment `recover_cnt_o`, saturating at all ones. Next state is IDLE.
- FAIL: `fail_o`=1 and `reset_o[core_sel]`=0, both held. Leaves FAIL only through `rst_i`; all `error_i` are ignored.
- `error_i` changes in any state other than IDLE are ignored, including errors from other cores. A level still asserted when the FSM returns to IDLE starts a new recovery on the next edge.
- Outside WORK_SPC and WORK_SGPR, `replay_addr_o` holds its last value.

## Timing
- Let `error_i` be sampled high in IDLE at edge k. The FSM is then:
  - in RESET during cycle k+1;
  - in HALT during k+2;
  - in HALT_WAIT from k+3.
- With `halted_i` already high: WORK_SPC at k+4, WORK_SGPR at k+5 through k+4+R where R = `NUM_REG`-`SKIP_X0`, DONE at k+5+R, IDLE at k+6+R.
- Defaults give R=31, so DONE occurs at k+36.
- Each timeout retry costs `HALT_TIMEOUT`+2 cycles (RESET, HALT, and the full wait).
- The earliest possible FAIL is reached after `MAX_RETRIES` × (`HALT_TIMEOUT`+2) cycles of waiting, measured from RESET.
- `core_sel_o` is stable from RESET through DONE, and in FAIL.

## Test plan
- Single recovery, defaults:
  - stimulus: `error_i`=2'b10 for one cycle, `halted_i[1]` tied high;
  - required: `core_sel_o`=1, `reset_o`=2'b01 for exactly 1 cycle, one `we_spc_o` pulse, 31 `we_sgpr_o` cycles with addresses 1..31, `resume_o` 36 cycles after the error, `recover_cnt_o`=1.
- Simultaneous errors:
  - stimulus: `error_i`=2'b11 held for 40 cycles;
  - required: core 0 is recovered first, and core 1 is never recovered while `error_i[0]` stays high.
  - stimulus: `error_i`=2'b10 after the first DONE;
  - required: a second recovery of core 1, and `recover_cnt_o`=2.
- Timeout with recovery:
  - stimulus: `halted_i` held low for the first 16 cycles of HALT_WAIT;
  - required: RESET and HALT are re-entered.
  - stimulus: `halted_i` high during the second attempt;
  - required: recovery completes normally.
- Exhaustion:
  - stimulus: `halted_i` never asserted;
  - required: FAIL is entered after 3 timeouts, `fail_o`=1, `reset_o[core_sel]`=0 and `busy_o`=0, all held across 100 cycles.
  - stimulus: `rst_i` pulse;
  - required: all outputs return to their reset values.
- SKIP_X0=0 with ADDR_WIDTH=3:
  - required: replay covers addresses 0..7 (8 `we_sgpr_o` cycles).
  - stimulus: `rst_i` asserted while in WORK_SGPR at address 4;
  - required: IDLE on the next cycle, with `we_sgpr_o`=0.
